// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative divider.
//   div_state_e  : divider control states
//   DefaultWidth : default operand/result width
//   DivZeroQuot  : quotient returned on divide by zero (all ones)
package mdu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam int unsigned DefaultWidth = 32;

    // All-ones pattern; replicated from bit 0 when WIDTH differs from the default.
    localparam logic [DefaultWidth-1:0] DivZeroQuot = '1;

endpackage

// File: rtl/mdu_div_iter_if.sv
// mdu_div_iter_if: EX-stage divide request/response and stall/flush signals.
//   master : pipeline side (drives operands, flush, pipe_stall; receives results, stall_req)
//   slave  : divider side
interface mdu_div_iter_if import mdu_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic             flush;
    logic             pipe_stall;
    logic             div_valid;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall_req;
    logic             res_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output flush, pipe_stall, div_valid, div_signed, dividend, divisor,
        input  stall_req, res_valid, quotient, remainder
    );

    modport slave (
        input  flush, pipe_stall, div_valid, div_signed, dividend, divisor,
        output stall_req, res_valid, quotient, remainder
    );

endinterface

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step.
//   rem_i     : partial remainder (always < divisor_i when divisor_i != 0)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this step
module div_iter_step import mdu_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        // shifted < 2*divisor, so a set MSB of the difference means it went negative.
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: iterative radix-2 signed/unsigned divider for the EX stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mdu_div_iter_if.slave (flush, pipe_stall, div_valid, div_signed, dividend,
//              divisor in; stall_req, res_valid, quotient, remainder out)
// Holds EX via stall_req for WIDTH+1 cycles, then presents registered results until EX
// advances. Build option MDU_EARLY_OUT_EN: divide-by-zero and |dividend| < |divisor|
// finish in the accept cycle (results are identical either way).
module mdu_div_iter import mdu_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic           clk,
    input logic           rst,
    mdu_div_iter_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dd_q, dd_d;         // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] dd_raw_q, dd_raw_d; // unmodified dividend for the divide-by-zero result
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             res_valid_q, res_valid_d;
    logic             stall_c;

    logic             dd_neg, dvs_neg, div_zero;
    logic [WIDTH-1:0] dd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] fin_quo, fin_rem;
    logic [WIDTH-1:0] dbz_quo;

    assign dbz_quo = {WIDTH{DivZeroQuot[0]}};

    // Operand decode for the accept cycle.
    always_comb begin
        dd_neg   = bus.div_signed & bus.dividend[WIDTH-1];
        dvs_neg  = bus.div_signed & bus.divisor[WIDTH-1];
        dd_mag   = dd_neg ? -bus.dividend : bus.dividend;
        dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
        div_zero = (bus.divisor == '0);
    end

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    // Final-step result with sign correction; min / -1 falls out naturally as min.
    always_comb begin
        q_mag   = {dd_q[WIDTH-2:0], step_bit};
        fin_quo = dbz_q ? dbz_quo  : (quo_neg_q ? -q_mag : q_mag);
        fin_rem = dbz_q ? dd_raw_q : (rem_neg_q ? -step_rem : step_rem);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dd_d        = dd_q;
        dvs_d       = dvs_q;
        dd_raw_d    = dd_raw_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        stall_c     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.div_valid && !bus.flush) begin
                    stall_c   = 1'b1;
                    rem_d     = '0;
                    dd_d      = dd_mag;
                    dvs_d     = dvs_mag;
                    dd_raw_d  = bus.dividend;
                    quo_neg_d = dd_neg ^ dvs_neg;
                    rem_neg_d = dd_neg;
                    dbz_d     = div_zero;
                    cnt_d     = CntW'(WIDTH);
                    state_d   = StCalc;
`ifdef MDU_EARLY_OUT_EN
                    if (div_zero || (dd_mag < dvs_mag)) begin
                        quotient_d  = div_zero ? dbz_quo : '0;
                        remainder_d = bus.dividend;
                        state_d     = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                stall_c = 1'b1;
                rem_d   = step_rem;
                dd_d    = q_mag;
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
                    state_d     = StDone;
                end
            end
            StDone: begin
                // div_valid is still high here; it is absorbed, not restarted.
                if (!bus.pipe_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts everything and leaves the previous results untouched.
        if (bus.flush) begin
            state_d     = StIdle;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            stall_c     = 1'b0;
        end

        res_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            dd_q        <= '0;
            dvs_q       <= '0;
            dd_raw_q    <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dd_q        <= dd_d;
            dvs_q       <= dvs_d;
            dd_raw_q    <= dd_raw_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.stall_req = stall_c & ~rst;
    assign bus.res_valid = res_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule
